// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 codes, requester FSM states and byte/half lane helpers
package riscv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD_STB, RD_WAIT, MERGE, WR_STB, WR_WAIT, RESP} state_t;

    // Any funct3 that is neither byte nor half behaves as a word access
    function automatic logic is_b(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    function automatic logic is_h(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return is_h(f3) ? a[0] : (!is_b(f3) && a != 2'b00);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0] b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        return is_b(f3) ? {{24{b[7] & ~f3[2]}}, b} :
               is_h(f3) ? {{16{h[15] & ~f3[2]}}, h} : w;
    endfunction

    // Only called for SB/SH; anything that is not a byte is a half merge
    function automatic logic [31:0] lane_merge(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w, input logic [15:0] d);
        logic [31:0] m;
        m = 32'h0000_00ff << {a, 3'b000};
        return is_b(f3) ? ((w & ~m) | ({24'b0, d[7:0]} << {a, 3'b000})) :
               a[1] ? {d, w[15:0]} : {w[31:16], d};
    endfunction
endpackage

// File: rtl/cache_requester_if.sv
// cache_requester_if: load/store request/response handshake plus word-addressed cache port
interface cache_requester_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] c_addr;
    logic [31:0] c_din;
    logic        c_we;
    logic        c_rreq;
    logic [31:0] c_dout;
    logic        c_rdy;
`ifdef CACHE_REQUESTER_MISALIGN_EN
    logic        rsp_misalign;
`endif

    modport master (
`ifdef CACHE_REQUESTER_MISALIGN_EN
        output rsp_misalign,
`endif
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, c_dout, c_rdy,
        output req_ready, rsp_valid, rsp_rdata, c_addr, c_din, c_we, c_rreq
    );

    modport slave (
`ifdef CACHE_REQUESTER_MISALIGN_EN
        input  rsp_misalign,
`endif
        output req_valid, req_we, req_funct3, req_addr, req_wdata, c_dout, c_rdy,
        input  req_ready, rsp_valid, rsp_rdata, c_addr, c_din, c_we, c_rreq
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: sub-word store merge and load extract/extend by funct3 and address lane
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);
    assign ld_data = lane_extract(funct3, lane, ld_word);
    assign st_data = lane_merge(funct3, lane, st_word, wdata);
endmodule

// File: rtl/cache_requester.sv
// cache_requester: byte-addressed RISC-V load/store front end for a word cache, RMW for SB/SH.
// CACHE_REQUESTER_MISALIGN_EN adds rsp_misalign and rejects misaligned H/W accesses without a strobe.
module cache_requester
    import riscv_mem_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int ADDR_SHIFT    = 2
) (
    input logic clk,
    input logic rst,
    cache_requester_if.master bus
);
    state_t      state;
    logic [2:0]  f3;
    logic        we;
    logic [1:0]  lane;
    logic [15:0] wdata;
    logic [31:0] word;
    logic [7:0]  cnt;
    logic        skip;
    logic        done;
    logic        mis;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    mem_lane_align u_align (
        .funct3 (f3),
        .lane   (lane),
        .ld_word(bus.c_dout),
        .st_word(word),
        .wdata  (wdata),
        .ld_data(ld_data),
        .st_data(st_data)
    );

    assign done = cnt == 8'(STROBE_CYCLES - 1);
`ifdef CACHE_REQUESTER_MISALIGN_EN
    assign mis = misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            f3            <= F3_W;
            we            <= 1'b0;
            lane          <= 2'b00;
            wdata         <= '0;
            word          <= '0;
            cnt           <= '0;
            skip          <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.c_addr    <= '0;
            bus.c_din     <= '0;
            bus.c_we      <= 1'b0;
            bus.c_rreq    <= 1'b0;
`ifdef CACHE_REQUESTER_MISALIGN_EN
            bus.rsp_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    f3            <= bus.req_funct3;
                    we            <= bus.req_we;
                    lane          <= bus.req_addr[1:0];
                    wdata         <= bus.req_wdata[15:0];
                    bus.c_addr    <= bus.req_addr >> ADDR_SHIFT;
                    bus.rsp_rdata <= '0;
                    bus.req_ready <= 1'b0;
                    cnt           <= '0;
`ifdef CACHE_REQUESTER_MISALIGN_EN
                    bus.rsp_misalign <= mis;
`endif
                    if (mis) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (bus.req_we && !is_b(bus.req_funct3) && !is_h(bus.req_funct3)) begin
                        bus.c_din <= bus.req_wdata;
                        bus.c_we  <= 1'b1;
                        state     <= WR_STB;
                    end else begin
                        bus.c_rreq <= 1'b1;
                        state      <= RD_STB;
                    end
                end
                RD_STB: begin
                    cnt <= cnt + 8'd1;
                    if (done) begin
                        bus.c_rreq <= 1'b0;
                        skip       <= 1'b1;
                        state      <= RD_WAIT;
                    end
                end
                // The first post-strobe cycle is skipped so a leftover RDY cannot complete us
                RD_WAIT: begin
                    skip <= 1'b0;
                    if (!skip && bus.c_rdy) begin
                        word <= bus.c_dout;
                        if (we) state <= MERGE;
                        else begin
                            bus.rsp_rdata <= ld_data;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end
                MERGE: begin
                    bus.c_din <= st_data;
                    bus.c_we  <= 1'b1;
                    cnt       <= '0;
                    state     <= WR_STB;
                end
                WR_STB: begin
                    cnt <= cnt + 8'd1;
                    if (done) begin
                        bus.c_we <= 1'b0;
                        skip     <= 1'b1;
                        state    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    skip <= 1'b0;
                    if (!skip && bus.c_rdy) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_requester.md
Name: cache_requester

Overview:
- Initiator side of the word-addressed cache port (ADDR/DIN/WE/RREQ/DOUT/RDY).
- Sits between the RISC-V load/store stage and the cache. Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Drives cache strobes and waits for RDY. Sub-word stores are done as read-modify-write; sub-word loads are extracted and sign- or zero-extended.

Parameters:
- STROBE_CYCLES, 2, cycles C_RREQ/C_WE are held high per cache transaction (min 1)
- ADDR_SHIFT, 2, byte-to-word address shift applied to REQ_ADDR to form C_ADDR

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block idle, request accepted when VALID&READY
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data (low byte/half used for SB/SH)
- RSP_VALID  out  1  one-cycle pulse: transaction complete
- RSP_RDATA  out  32  extended load data; valid when RSP_VALID, 0 for stores
- C_ADDR  out  32  word address to cache
- C_DIN  out  32  write data to cache
- C_WE  out  1  cache write strobe
- C_RREQ  out  1  cache read strobe
- C_DOUT  in  32  cache read data
- C_RDY  in  1  cache idle/complete

Behaviour:
- Reset (async, any state):
  - State = IDLE; REQ_READY=1.
  - RSP_VALID, C_WE, C_RREQ = 0; RSP_RDATA, C_ADDR, C_DIN = 0.
  - Any in-flight transaction is abandoned with no RSP_VALID.
- States: IDLE, RD_STB, RD_WAIT, MERGE, WR_STB, WR_WAIT, RESP.
- IDLE:
  - REQ_READY=1.
  - On VALID, latch ADDR, WE, FUNCT3, WDATA; set C_ADDR = REQ_ADDR >> ADDR_SHIFT.
  - Next state: SW goes to WR_STB with C_DIN=WDATA; every load, SB and SH goes to RD_STB.
- RD_STB / WR_STB:
  - C_RREQ (resp. C_WE) is high for exactly STROBE_CYCLES cycles, counted by an internal counter.
  - Then the strobe drops and the FSM moves to *_WAIT.
- *_WAIT:
  - C_RDY is ignored in the first cycle after strobe deassertion, so a stale RDY cannot complete the transaction.
  - Thereafter the first cycle with C_RDY=1 completes the transaction.
  - RD_WAIT, on completion: latch C_DOUT. A load goes to RESP. SB/SH go to MERGE.
  - WR_WAIT, on completion: goes to RESP.
- MERGE (1 cycle): C_DIN = latched word with byte lane ADDR[1:0] (SB) or half lane ADDR[1] (SH) replaced by WDATA low bits; next WR_STB.
- RESP (1 cycle):
  - RSP_VALID=1; next IDLE.
  - RSP_RDATA for loads: byte/half selected by ADDR[1:0], sign-extended (B/H) or zero-extended (BU/HU); W passes through.
- Sequencing:
  - REQ_READY=0 in every state except IDLE.
  - A new request can be accepted in the IDLE cycle after RESP.
  - Minimum latency, accept to RSP_VALID: load or SW = STROBE_CYCLES+3 cycles with immediate RDY; SB/SH = 2*STROBE_CYCLES+6.
- C_ADDR/C_DIN are held stable from strobe assertion until the transaction leaves *_WAIT.
- Unsupported FUNCT3 (011, 11x) is treated as W.
- Misalignment without the optional feature: SH/LH/LHU use ADDR[1] only; LW/SW ignore ADDR[1:0].

Optional Feature:
- Macro: CACHE_REQUESTER_MISALIGN_EN.
- Defined:
  - Extra output RSP_MISALIGN (1 bit, reset 0).
  - A halfword access with ADDR[0]=1, or a word access with ADDR[1:0]!=0, issues no cache strobe. It goes IDLE -> RESP with RSP_MISALIGN=1 and RSP_RDATA=0.
  - RSP_MISALIGN=0 on every other response.
- Undefined: port absent; misaligned bits are ignored as stated above.

Decomposition:
- Shared package riscv_mem_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum encoding.
  - Lane-extract and lane-merge functions.
- One sub-module, mem_lane_align: combinational merge (store) and extract/extend (load), keyed by funct3 and ADDR[1:0]. The FSM stays in cache_requester.

Test Plan:
- LW addr 0x58, cache returns 0xFFFFE8CA -> C_ADDR=22; C_RREQ high 2 cycles; RSP_RDATA=0xFFFFE8CA; RSP_VALID exactly 1 cycle.
- SW addr 0x08 data 0x00000007 -> C_ADDR=2, C_DIN=7, C_WE 2 cycles, C_RREQ never asserted; a subsequent LW 0x08 returns 7.
- Word at addr 2 holds 0x11223344:
  - SB addr 0x09 data 0xAA -> read then write with C_DIN=0x1122AA44.
  - Then LB 0x09 -> 0xFFFFFFAA; LBU 0x09 -> 0x000000AA.
- LH 0x0A on word 0x80017FFF -> 0xFFFF8001; LHU 0x0A -> 0x00008001.
- Stale-RDY case: C_RDY held 1 throughout and cache delays data 5 cycles after strobe -> completion is not taken in the first post-strobe cycle. Also check REQ_READY=0 and that VALID is ignored while busy.
- RST pulsed in RD_WAIT -> all outputs 0 asynchronously, REQ_READY=1, no RSP_VALID. With CACHE_REQUESTER_MISALIGN_EN: LW 0x06 -> RSP_MISALIGN=1, no strobe.
